// File: rtl/tcdm_interconnect_pkg.sv
// Shared types and limits for the TCDM interconnect blocks.
package tcdm_interconnect_pkg;

    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;

    localparam int unsigned MaxBankLat = 4;

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Response pipe: shifts {valid, requester index} so the response returns to the
// requester that was granted Depth cycles earlier.
module tcdm_resp_pipe
    import tcdm_interconnect_pkg::*;
#(
    parameter int unsigned Depth    = 1,
    parameter int unsigned IdxWidth = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [IdxWidth-1:0] idx_i,
    output logic                valid_o,
    output logic [IdxWidth-1:0] idx_o
);

    logic [Depth-1:0]    validQ;
    logic [IdxWidth-1:0] idxQ [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            validQ <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                idxQ[i] <= '0;
            end
        end else begin
            validQ[0] <= valid_i;
            idxQ[0]   <= idx_i;
            for (int i = 1; i < int'(Depth); i++) begin
                validQ[i] <= validQ[i-1];
                idxQ[i]   <= idxQ[i-1];
            end
        end
    end

    assign valid_o = validQ[Depth-1];
    assign idx_o   = idxQ[Depth-1];

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Arbitrates NumIn requesters onto one single-port TCDM bank and routes responses back.
// Optional conflict counter enabled by defining TCDM_ARB_PERF_EN.
module tcdm_bank_arbiter
    import tcdm_interconnect_pkg::*;
#(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned RespLat   = 1,
    parameter arb_mode_e   ArbMode   = ARB_RR,
    localparam int unsigned BeWidth  = DataWidth / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumIn-1:0]           req_i,
    input  logic [NumIn*AddrWidth-1:0] add_i,
    input  logic [NumIn-1:0]           wen_i,
    input  logic [NumIn*DataWidth-1:0] wdata_i,
    input  logic [NumIn*BeWidth-1:0]   be_i,
    output logic [NumIn-1:0]           gnt_o,
    output logic [NumIn-1:0]           vld_o,
    output logic [DataWidth-1:0]       rdata_o,
    output logic                       bank_req_o,
    output logic                       bank_we_o,
    output logic [AddrWidth-1:0]       bank_add_o,
    output logic [DataWidth-1:0]       bank_wdata_o,
    output logic [BeWidth-1:0]         bank_be_o,
    input  logic [DataWidth-1:0]       bank_rdata_i,
    input  logic                       cnt_clr_i,
    output logic [31:0]                conflict_cnt_o
);

    localparam int unsigned IdxWidth = $clog2(NumIn);

    if (NumIn < 2) begin : gNumInChk
        $error("tcdm_bank_arbiter: NumIn must be >= 2");
    end
    if (RespLat < 1 || RespLat > MaxBankLat) begin : gLatChk
        $error("tcdm_bank_arbiter: RespLat must be within 1..MaxBankLat");
    end
    if (DataWidth % 8 != 0) begin : gWidthChk
        $error("tcdm_bank_arbiter: DataWidth must be a multiple of 8");
    end

    logic                anyReq;
    logic [IdxWidth-1:0] rrQ, rrD;
    logic [IdxWidth-1:0] startIdx, cand, winner;
    logic                pipeValid;
    logic [IdxWidth-1:0] pipeIdx;

    assign anyReq   = |req_i;
    assign startIdx = (ArbMode == ARB_RR) ? rrQ : '0;

    // Walk offsets from the far end so the closest requester to startIdx wins last.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = int'(NumIn) - 1; k >= 0; k--) begin
            cand = IdxWidth'((int'(startIdx) + k) % NumIn);
            if (req_i[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        rrD = rrQ;
        if (ArbMode == ARB_RR && anyReq) begin
            rrD = (winner == IdxWidth'(NumIn - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rrQ <= '0;
        end else begin
            rrQ <= rrD;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (anyReq) begin
            gnt_o[winner] = 1'b1;
        end
    end

    assign bank_req_o   = anyReq;
    assign bank_we_o    = wen_i[winner];
    assign bank_add_o   = add_i[winner*AddrWidth +: AddrWidth];
    assign bank_wdata_o = wdata_i[winner*DataWidth +: DataWidth];
    assign bank_be_o    = be_i[winner*BeWidth +: BeWidth];

    tcdm_resp_pipe #(
        .Depth   (RespLat),
        .IdxWidth(IdxWidth)
    ) uRespPipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(anyReq),
        .idx_i  (winner),
        .valid_o(pipeValid),
        .idx_o  (pipeIdx)
    );

    // Writes are acknowledged through the same path as reads.
    always_comb begin
        vld_o = '0;
        if (pipeValid) begin
            vld_o[pipeIdx] = 1'b1;
        end
    end

    assign rdata_o = bank_rdata_i;

`ifdef TCDM_ARB_PERF_EN
    logic [31:0] cntQ, cntD;
    logic        conflict;

    assign conflict = $countones(req_i) >= 2;

    always_comb begin
        cntD = cntQ;
        if (cnt_clr_i) begin
            cntD = '0;
        end else if (conflict && cntQ != 32'hFFFF_FFFF) begin
            cntD = cntQ + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign conflict_cnt_o = cntQ;
`else
    logic unusedCntClr;
    assign unusedCntClr   = cnt_clr_i;
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Bench for tcdm_bank_arbiter: a round-robin instance (RespLat=3) and a fixed-priority instance
// (RespLat=1) share stimulus and are compared each cycle against a behavioural model.
module tb_tcdm_bank_arbiter;
    import tcdm_interconnect_pkg::*;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int LatR = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*AW-1:0]   add = '0;
    logic [N-1:0]      wen = '0;
    logic [N*DW-1:0]   wdata = '0;
    logic [N*BW-1:0]   be = '0;
    logic [DW-1:0]     bankRdata = '0;
    logic              cntClr = 1'b0;

    logic [N-1:0]  gntR, vldR, gntF, vldF;
    logic [DW-1:0] rdataR, rdataF, bankWdataR, bankWdataF;
    logic          bankReqR, bankWeR, bankReqF, bankWeF;
    logic [AW-1:0] bankAddR, bankAddF;
    logic [BW-1:0] bankBeR, bankBeF;
    logic [31:0]   cntR, cntF;

    int nChecks = 0;
    int nPass   = 0;

    tcdm_bank_arbiter #(
        .NumIn(N), .AddrWidth(AW), .DataWidth(DW), .RespLat(LatR), .ArbMode(ARB_RR)
    ) dutRr (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .be_i(be), .gnt_o(gntR), .vld_o(vldR), .rdata_o(rdataR), .bank_req_o(bankReqR),
        .bank_we_o(bankWeR), .bank_add_o(bankAddR), .bank_wdata_o(bankWdataR),
        .bank_be_o(bankBeR), .bank_rdata_i(bankRdata), .cnt_clr_i(cntClr),
        .conflict_cnt_o(cntR)
    );

    tcdm_bank_arbiter #(
        .NumIn(N), .AddrWidth(AW), .DataWidth(DW), .RespLat(1), .ArbMode(ARB_FIXED)
    ) dutFx (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .be_i(be), .gnt_o(gntF), .vld_o(vldF), .rdata_o(rdataF), .bank_req_o(bankReqF),
        .bank_we_o(bankWeF), .bank_add_o(bankAddF), .bank_wdata_o(bankWdataF),
        .bank_be_o(bankBeF), .bank_rdata_i(bankRdata), .cnt_clr_i(cntClr),
        .conflict_cnt_o(cntF)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end else begin
            nPass++;
        end
    endtask

    // First requester found scanning start, start+1, ... mod N; -1 when nobody asks.
    function automatic int pick(input logic [N-1:0] r, input int start);
        int idx;
        for (int off = 0; off < N; off++) begin
            idx = (start + off) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oneHot(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic int popCount(input logic [N-1:0] r);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(r[i]);
        return c;
    endfunction

    // Model state: next round-robin start, grant history (newest first), conflict count.
    int          rrM = 0;
    int          histR [LatR] = '{default: -1};
    int          histF = -1;
    logic [31:0] cntM = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rrM <= 0;
            for (int i = 0; i < LatR; i++) histR[i] <= -1;
            histF <= -1;
            cntM  <= '0;
        end else begin
            if (pick(req, rrM) >= 0) rrM <= (pick(req, rrM) + 1) % N;
            histR[0] <= pick(req, rrM);
            for (int i = 1; i < LatR; i++) histR[i] <= histR[i-1];
            histF <= pick(req, 0);
            if (cntClr) cntM <= '0;
            else if (popCount(req) >= 2 && cntM != 32'hFFFF_FFFF) cntM <= cntM + 1;
        end
    end

    int wR, wF;
    logic [31:0] expCnt;

    always @(negedge clk) begin
        wR = pick(req, rrM);
        wF = pick(req, 0);
`ifdef TCDM_ARB_PERF_EN
        expCnt = cntM;
`else
        expCnt = '0;
`endif
        chk("rr_gnt", 64'(gntR), 64'(oneHot(wR)));
        chk("fx_gnt", 64'(gntF), 64'(oneHot(wF)));
        chk("rr_bank_req", 64'(bankReqR), 64'(|req));
        chk("fx_bank_req", 64'(bankReqF), 64'(|req));
        if (wR >= 0) begin
            chk("rr_bank_we", 64'(bankWeR), 64'(wen[wR]));
            chk("rr_bank_add", 64'(bankAddR), 64'(add[wR*AW +: AW]));
            chk("rr_bank_wdata", 64'(bankWdataR), 64'(wdata[wR*DW +: DW]));
            chk("rr_bank_be", 64'(bankBeR), 64'(be[wR*BW +: BW]));
        end
        if (wF >= 0) begin
            chk("fx_bank_we", 64'(bankWeF), 64'(wen[wF]));
            chk("fx_bank_add", 64'(bankAddF), 64'(add[wF*AW +: AW]));
            chk("fx_bank_wdata", 64'(bankWdataF), 64'(wdata[wF*DW +: DW]));
            chk("fx_bank_be", 64'(bankBeF), 64'(be[wF*BW +: BW]));
        end
        chk("rr_vld", 64'(vldR), 64'(oneHot(histR[LatR-1])));
        chk("fx_vld", 64'(vldF), 64'(oneHot(histF)));
        if (histR[LatR-1] >= 0) chk("rr_rdata", 64'(rdataR), 64'(bankRdata));
        if (histF >= 0) chk("fx_rdata", 64'(rdataF), 64'(bankRdata));
        chk("rr_conflict_cnt", 64'(cntR), 64'(expCnt));
        chk("fx_conflict_cnt", 64'(cntF), 64'(expCnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("lit_reset_gnt", 64'(gntR), 64'h0);
        chk("lit_reset_vld", 64'(vldR), 64'h0);
        chk("lit_reset_cnt", 64'(cntR), 64'h0);
        tick();

        // All four requesting: RR rotates, fixed always picks 0.
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("lit_rr_rotate", 64'(gntR), 64'(4'b0001 << (k % 4)));
            chk("lit_fx_all", 64'(gntF), 64'h1);
            if (k >= 1) chk("lit_fx_vld", 64'(vldF), 64'h1);
            if (k >= 3) chk("lit_rr_vld", 64'(vldR), 64'(4'b0001 << ((k - 3) % 4)));
            tick();
        end

        // Bring rr to 2, then 0011 wraps 3->0.
        req = 4'b0010;
        @(negedge clk); chk("lit_rr_set2", 64'(gntR), 64'h2);
        tick();
        req = 4'b0011;
        @(negedge clk); chk("lit_rr_wrap0", 64'(gntR), 64'h1);
        tick();
        @(negedge clk); chk("lit_rr_wrap1", 64'(gntR), 64'h2);
        tick();
        req = 4'b1111;
        @(negedge clk); chk("lit_rr_is2", 64'(gntR), 64'h4);
        tick();

        req = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("lit_fx_starve", 64'(gntF), 64'h2);
            tick();
        end

        req = '0;
        repeat (3) tick();
        // Read by requester 1, data returns three cycles later.
        req = 4'b0010;
        add = 40'(5) << AW;
        wen = '0;
        @(negedge clk);
        chk("lit_read_add", 64'(bankAddR), 64'h5);
        chk("lit_read_we", 64'(bankWeR), 64'h0);
        tick();
        req = '0;
        tick();
        tick();
        bankRdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lit_read_vld", 64'(vldR), 64'h2);
        chk("lit_read_rdata", 64'(rdataR), 64'hDEAD_BEEF);
        tick();
        // Write by requester 2 is acknowledged on the same schedule.
        req = 4'b0100;
        wen = 4'b0100;
        wdata = 128'(32'h1234_5678) << (2 * DW);
        @(negedge clk);
        chk("lit_write_we", 64'(bankWeR), 64'h1);
        chk("lit_write_wdata", 64'(bankWdataR), 64'h1234_5678);
        tick();
        req = '0;
        tick();
        tick();
        @(negedge clk); chk("lit_write_vld", 64'(vldR), 64'h4);
        tick();

        // Reset one cycle after a grant discards the response.
        req = 4'b0001;
        tick();
        req = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lit_rst_rr_vld", 64'(vldR), 64'h0);
            chk("lit_rst_fx_vld", 64'(vldF), 64'h0);
            tick();
        end
        req = 4'b1111;
        @(negedge clk); chk("lit_rst_first_gnt", 64'(gntR), 64'h1);
        tick();

        // Conflict counter: 5 conflicting cycles, 2 clean, then clear.
        req = '0;
        cntClr = 1'b1;
        tick();
        cntClr = 1'b0;
        req = 4'b0101;
        repeat (5) tick();
        req = 4'b0001;
        repeat (2) tick();
        @(negedge clk);
`ifdef TCDM_ARB_PERF_EN
        chk("lit_cnt_five", 64'(cntR), 64'd5);
`else
        chk("lit_cnt_off", 64'(cntR), 64'd0);
`endif
        tick();
        cntClr = 1'b1;
        req = '0;
        tick();
        cntClr = 1'b0;
        @(negedge clk); chk("lit_cnt_clr", 64'(cntR), 64'd0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            req = 4'($urandom) & ($urandom_range(0, 1) == 1 ? 4'hF : 4'($urandom));
            add = 40'({$urandom, $urandom});
            wen = 4'($urandom);
            wdata = {$urandom, $urandom, $urandom, $urandom};
            be = 16'($urandom);
            bankRdata = $urandom;
            cntClr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
            tick();
        end

        req = '0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
